// File: rtl/pbit_pkg.sv
// Shared types and width helpers for the p-bit update scheduler.
package pbit_pkg;

    typedef enum logic [1:0] {IDLE, ON, GAP} sched_state_e;
    typedef enum logic {SEQ = 1'b0, COLOUR = 1'b1} sched_mode_e;

    // Address width for a range of v values; never narrower than one bit.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 1;
        while ((64'd1 << r) < 64'(v)) r = r + 1;
        return r;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pbit_grp_mask_ram.sv
// Colour group-mask table: sync write, async read, sync clear on RST.
module pbit_grp_mask_ram #(
    parameter int unsigned N_PBITS    = 5,
    parameter int unsigned MAX_GROUPS = 8,
    parameter int unsigned AW         = 3
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [N_PBITS-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [N_PBITS-1:0] rdata
);

    logic [N_PBITS-1:0] mem [MAX_GROUPS];

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < MAX_GROUPS; i++) mem[i] <= '0;
        end else if (we && ({1'b0, waddr} < (AW+1)'(MAX_GROUPS))) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = ({1'b0, raddr} < (AW+1)'(MAX_GROUPS)) ? mem[raddr] : '0;

endmodule

// File: rtl/pbit_update_sched.sv
// Update-strobe scheduler for a p-bit array: SEQ round-robin or COLOUR group masks,
// each slot held ON_CYCLES then followed by GAP_CYCLES of all-zero settling.
module pbit_update_sched
    import pbit_pkg::*;
#(
    parameter int unsigned N_PBITS    = 5,
    parameter int unsigned ON_CYCLES  = 2,
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned MAX_GROUPS = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                                          CLK,
    input  logic                                          RST,
    input  logic                                          EN,
    input  logic                                          MODE,
    input  logic [clog2(MAX_GROUPS+1)-1:0]                N_GROUPS,
    input  logic                                          GRP_WE,
    input  logic [clog2(MAX_GROUPS)-1:0]                  GRP_ADDR,
    input  logic [N_PBITS-1:0]                            GRP_DATA,
    output logic [N_PBITS-1:0]                            update_sequence,
    output logic [clog2(max2(N_PBITS, MAX_GROUPS))-1:0]   slot_idx,
    output logic                                          busy,
    output logic                                          sweep_done,
    output logic [CNT_W-1:0]                              sweep_count
);

    localparam int unsigned GW = clog2(MAX_GROUPS + 1);
    localparam int unsigned AW = clog2(MAX_GROUPS);
    localparam int unsigned SW = clog2(max2(N_PBITS, MAX_GROUPS));
    localparam int unsigned PW = clog2(max2(ON_CYCLES, GAP_CYCLES) + 1);

    localparam logic [PW-1:0] ON_LAST  = PW'(ON_CYCLES - 1);
    localparam logic [PW-1:0] GAP_LAST = PW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
    localparam logic [SW-1:0] SEQ_LAST = SW'(N_PBITS - 1);

    sched_state_e       state, state_n;
    sched_mode_e        mode_q, mode_n;
    logic [PW-1:0]      phase, phase_n;
    logic [SW-1:0]      slot_n, last_q, last_n, start_last;
    logic [GW-1:0]      ngrp_eff;
    logic [N_PBITS-1:0] tbl_rdata, mask_n, update_n;
    logic               start, adv, done_n;

    pbit_grp_mask_ram #(
        .N_PBITS    (N_PBITS),
        .MAX_GROUPS (MAX_GROUPS),
        .AW         (AW)
    ) u_ram (
        .CLK   (CLK),
        .RST   (RST),
        .we    (GRP_WE),
        .waddr (GRP_ADDR),
        .wdata (GRP_DATA),
        .raddr (AW'(slot_n)),
        .rdata (tbl_rdata)
    );

    always_comb begin
        ngrp_eff = N_GROUPS;
        if (N_GROUPS == '0) ngrp_eff = GW'(1);
        else if (N_GROUPS > GW'(MAX_GROUPS)) ngrp_eff = GW'(MAX_GROUPS);
        start_last = MODE ? SW'(ngrp_eff - 1'b1) : SEQ_LAST;
    end

    always_comb begin
        state_n = state;
        phase_n = phase;
        slot_n  = slot_idx;
        mode_n  = mode_q;
        last_n  = last_q;
        start   = 1'b0;
        adv     = 1'b0;
        unique case (state)
            IDLE: start = EN;
            ON: begin
                if (phase != ON_LAST) phase_n = phase + 1'b1;
                else if (GAP_CYCLES != 0) begin
                    state_n = GAP;
                    phase_n = '0;
                end else adv = 1'b1;
            end
            GAP: begin
                if (phase != GAP_LAST) phase_n = phase + 1'b1;
                else adv = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        // EN is only consulted at slot boundaries so a running slot always completes.
        if (adv) begin
            slot_n = (slot_idx == last_q) ? '0 : slot_idx + 1'b1;
            if (EN) start = 1'b1;
            else begin
                state_n = IDLE;
                phase_n = '0;
            end
        end
        if (start) begin
            state_n = ON;
            phase_n = '0;
            if (slot_n == '0) begin
                mode_n = MODE ? COLOUR : SEQ;
                last_n = start_last;
            end
        end
    end

    always_comb begin
        mask_n   = (mode_n == COLOUR) ? tbl_rdata : (N_PBITS'(1) << slot_n);
        update_n = '0;
        if (state_n == ON) update_n = start ? mask_n : update_sequence;
        done_n = (slot_n == last_n) &&
                 (((state_n == GAP) && (phase_n == GAP_LAST)) ||
                  ((GAP_CYCLES == 0) && (state_n == ON) && (phase_n == ON_LAST)));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state           <= IDLE;
            phase           <= '0;
            slot_idx        <= '0;
            mode_q          <= SEQ;
            last_q          <= SEQ_LAST;
            update_sequence <= '0;
            busy            <= 1'b0;
            sweep_done      <= 1'b0;
            sweep_count     <= '0;
        end else begin
            state           <= state_n;
            phase           <= phase_n;
            slot_idx        <= slot_n;
            mode_q          <= mode_n;
            last_q          <= last_n;
            update_sequence <= update_n;
            busy            <= (state_n != IDLE);
            sweep_done      <= done_n;
            sweep_count     <= sweep_count + CNT_W'(done_n);
        end
    end

endmodule

// File: tb/tb_pbit_update_sched.sv
// Scoreboard bench: a slot-plan reference model queues expected outputs; a monitor compares.
module tb_pbit_update_sched;

    localparam int ON  = 2;
    localparam int GAP = 1;

    logic       CLK = 1'b0;
    logic       RST, EN, MODE, GRP_WE;
    logic [3:0] N_GROUPS;
    logic [2:0] GRP_ADDR;
    logic [4:0] GRP_DATA;
    logic [4:0] us;
    logic [2:0] slot;
    logic       busy, done;
    logic [15:0] cnt;

    logic        rst2, en2;
    logic [4:0]  us2;
    logic [2:0]  slot2;
    logic        busy2, done2;
    logic [15:0] cnt2;

    always #5 CLK = ~CLK;

    pbit_update_sched #(.N_PBITS(5), .ON_CYCLES(ON), .GAP_CYCLES(GAP), .MAX_GROUPS(8), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE), .N_GROUPS(N_GROUPS),
        .GRP_WE(GRP_WE), .GRP_ADDR(GRP_ADDR), .GRP_DATA(GRP_DATA),
        .update_sequence(us), .slot_idx(slot), .busy(busy), .sweep_done(done), .sweep_count(cnt));

    pbit_update_sched #(.N_PBITS(5), .ON_CYCLES(1), .GAP_CYCLES(0), .MAX_GROUPS(8), .CNT_W(16)) dut2 (
        .CLK(CLK), .RST(rst2), .EN(en2), .MODE(1'b0), .N_GROUPS(4'd0),
        .GRP_WE(1'b0), .GRP_ADDR(3'd0), .GRP_DATA(5'd0),
        .update_sequence(us2), .slot_idx(slot2), .busy(busy2), .sweep_done(done2), .sweep_count(cnt2));

    typedef struct { logic [4:0] us; logic [2:0] slot; logic busy; logic done; logic [15:0] cnt; } exp_t;
    typedef struct { logic [4:0] mask; int slot; logic done; } ent_t;

    exp_t q1[$];
    exp_t q2[$];
    ent_t plan[$];
    logic [4:0] tbl[8];
    int m_slot, m_last, m_cnt;
    bit m_colour;
    int d2_k = -1;
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference: whenever the schedule runs dry and EN is high, expand the next slot into
    // ON cycles of its mask followed by GAP zero cycles, then replay one entry per clock.
    task automatic model_step();
        exp_t e;
        ent_t x;
        int eff;
        logic [4:0] mask;
        if (RST) begin
            plan.delete();
            foreach (tbl[i]) tbl[i] = '0;
            m_slot = 0; m_last = 4; m_cnt = 0; m_colour = 0;
            e.us = '0; e.slot = '0; e.busy = 0; e.done = 0; e.cnt = '0;
        end else begin
            if (plan.size() == 0 && EN) begin
                if (m_slot == 0) begin
                    m_colour = MODE;
                    eff = (N_GROUPS == 0) ? 1 : ((N_GROUPS > 8) ? 8 : int'(N_GROUPS));
                    m_last = MODE ? eff - 1 : 4;
                end
                mask = m_colour ? tbl[m_slot] : 5'(1 << m_slot);
                for (int i = 0; i < ON; i++) begin
                    x.mask = mask; x.slot = m_slot; x.done = 0; plan.push_back(x);
                end
                for (int i = 0; i < GAP; i++) begin
                    x.mask = '0; x.slot = m_slot; x.done = 0; plan.push_back(x);
                end
                plan[plan.size()-1].done = (m_slot == m_last);
                m_slot = (m_slot == m_last) ? 0 : m_slot + 1;
            end
            if (plan.size() != 0) begin
                x = plan.pop_front();
                if (x.done) m_cnt = m_cnt + 1;
                e.us = x.mask; e.slot = 3'(x.slot); e.busy = 1; e.done = x.done; e.cnt = 16'(m_cnt);
            end else begin
                e.us = '0; e.slot = 3'(m_slot); e.busy = 0; e.done = 0; e.cnt = 16'(m_cnt);
            end
            if (GRP_WE) tbl[GRP_ADDR] = GRP_DATA;
        end
        q1.push_back(e);
    endtask

    task automatic model2_step();
        exp_t e;
        if (rst2) begin
            e.us = '0; e.slot = '0; e.busy = 0; e.done = 0; e.cnt = '0;
            q2.push_back(e);
        end else if (d2_k >= 0) begin
            e.us = 5'(1 << (d2_k % 5)); e.slot = 3'(d2_k % 5); e.busy = 1;
            e.done = (d2_k % 5 == 4); e.cnt = 16'((d2_k + 1) / 5);
            q2.push_back(e);
            d2_k++;
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_step();
        model2_step();
        #1;
        cyc++;
    endtask

    task automatic run(input int n, input logic en, input logic mode, input logic [3:0] ng);
        for (int i = 0; i < n; i++) begin
            EN = en; MODE = mode; N_GROUPS = ng; GRP_WE = 0; RST = 0;
            step();
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [4:0] d);
        GRP_WE = 1; GRP_ADDR = a; GRP_DATA = d; RST = 0;
        step();
        GRP_WE = 0;
    endtask

    task automatic do_reset(input int n);
        RST = 1; GRP_WE = 0;
        for (int i = 0; i < n; i++) step();
        RST = 0;
    endtask

    task automatic cmp(input string nm, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, got, want);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                cmp("update_sequence", 16'(us), 16'(e.us));
                cmp("slot_idx", 16'(slot), 16'(e.slot));
                cmp("busy", 16'(busy), 16'(e.busy));
                cmp("sweep_done", 16'(done), 16'(e.done));
                cmp("sweep_count", cnt, e.cnt);
            end
            if (q2.size() != 0) begin
                e = q2.pop_front();
                cmp("b2b_update_sequence", 16'(us2), 16'(e.us));
                cmp("b2b_slot_idx", 16'(slot2), 16'(e.slot));
                cmp("b2b_busy", 16'(busy2), 16'(e.busy));
                cmp("b2b_sweep_done", 16'(done2), 16'(e.done));
                cmp("b2b_sweep_count", cnt2, e.cnt);
            end
        end
    end

    initial begin
        EN = 0; MODE = 0; N_GROUPS = 0; GRP_WE = 0; GRP_ADDR = 0; GRP_DATA = 0;
        rst2 = 1; en2 = 0;
        do_reset(2);
        // round-robin from reset, through two sweeps
        run(32, 1, 0, 0);
        // colour groups, then a MODE switch mid-sweep
        do_reset(1);
        wr(0, 5'b10101);
        wr(1, 5'b01010);
        run(14, 1, 1, 4'd2);
        run(12, 1, 0, 4'd2);
        // EN dropped during slot 2 ON, then resumed
        do_reset(1);
        run(7, 1, 0, 0);
        run(8, 0, 0, 0);
        run(12, 1, 0, 0);
        // RST during slot 3 GAP clears everything including the table
        do_reset(1);
        wr(2, 5'b11111);
        run(11, 1, 0, 0);
        do_reset(1);
        run(6, 1, 1, 4'd3);
        // N_GROUPS 0 and 15 clamp; write to an in-flight slot
        wr(0, 5'b00111);
        wr(5, 5'b11000);
        run(9, 1, 1, 4'd0);
        run(4, 0, 1, 4'd0);
        run(2, 1, 1, 4'd15);
        wr(1, 5'b10001);
        run(26, 1, 1, 4'd15);
        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) EN = ~EN; else if ($urandom_range(0, 3) == 0) EN = 1;
            if ($urandom_range(0, 29) == 0) MODE = ~MODE;
            if ($urandom_range(0, 29) == 0) N_GROUPS = 4'($urandom_range(0, 15));
            GRP_WE = ($urandom_range(0, 3) == 0);
            GRP_ADDR = 3'($urandom_range(0, 7));
            GRP_DATA = 5'($urandom_range(0, 31));
            RST = ($urandom_range(0, 199) == 0);
            step();
        end
        RST = 0; GRP_WE = 0;
        // back-to-back slots on the second instance
        run(2, 0, 0, 0);
        en2 = 1; rst2 = 0; d2_k = 0;
        run(14, 0, 0, 0);
        d2_k = -1; rst2 = 1;
        run(1, 0, 0, 0);
        for (int i = 0; i < 4 && (q1.size() != 0 || q2.size() != 0); i++) @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (q1.size() != 0 || q2.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d want=0", q1.size() + q2.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
